// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, controller state encoding
// and the datapath widths used by the counter and ALU.
package cpu_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_INC    = 3'd2,
      S_DECODE = 3'd3,
      S_OPRD   = 3'd4,
      S_EXEC   = 3'd5,
      S_HALT   = 3'd6
   } state_t;

endpackage

// File: rtl/cpu_controller.sv
// Instruction sequencer: walks FETCH/INC/DECODE/OPRD/EXEC once per instruction
// and decodes the memory, PC, IR and accumulator strobes from state and opcode.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int OPW = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   output logic           load_ir,
   output logic           inc_pc,
   output logic           load_pc,
   output logic           load_acc,
   output logic           rd,
   output logic           wr,
   output logic           datactl_ena,
   output logic           halt
);

   state_t state;
   state_t next_state;
   logic   alu_op;

   assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The unused encoding falls into the default arm and recovers to IDLE.
   always_comb begin
      next_state  = S_IDLE;
      load_ir     = 1'b0;
      inc_pc      = 1'b0;
      load_pc     = 1'b0;
      load_acc    = 1'b0;
      rd          = 1'b0;
      wr          = 1'b0;
      datactl_ena = 1'b0;
      halt        = 1'b0;
      case (state)
         S_IDLE: begin
            next_state = S_FETCH;
         end
         S_FETCH: begin
            next_state = S_INC;
            rd         = 1'b1;
            load_ir    = 1'b1;
         end
         S_INC: begin
            next_state = S_DECODE;
            inc_pc     = 1'b1;
         end
         S_DECODE: begin
            next_state = (opcode == OP_HLT) ? S_HALT : S_OPRD;
         end
         S_OPRD: begin
            next_state = S_EXEC;
            if (alu_op) begin
               rd = 1'b1;
            end else if (opcode == OP_STO) begin
               datactl_ena = 1'b1;
            end
         end
         S_EXEC: begin
            next_state = S_FETCH;
            if (alu_op) begin
               rd       = 1'b1;
               load_acc = 1'b1;
            end else if (opcode == OP_STO) begin
               datactl_ena = 1'b1;
               wr          = 1'b1;
            end else if (opcode == OP_JMP) begin
               load_pc = 1'b1;
            end else if (opcode == OP_SKZ) begin
               inc_pc = zero;
            end
         end
         S_HALT: begin
            next_state = S_HALT;
            halt       = 1'b1;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus queues the expected output
// vector for each cycle, a negedge monitor pops and compares it.
module tb_cpu_controller;
   import cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] opcode;
   logic       zero;
   logic       load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
   logic [7:0] out_vec;

   logic [7:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cycle_no = 0;
   int cnt_ir = 0, cnt_inc = 0, cnt_ld_pc = 0, cnt_acc = 0, cnt_wr = 0;

   cpu_controller #(.OPW(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .zero        (zero),
      .load_ir     (load_ir),
      .inc_pc      (inc_pc),
      .load_pc     (load_pc),
      .load_acc    (load_acc),
      .rd          (rd),
      .wr          (wr),
      .datactl_ena (datactl_ena),
      .halt        (halt)
   );

   always #5 clk = ~clk;

   // Bit order: load_ir inc_pc load_pc load_acc rd wr datactl_ena halt
   assign out_vec = {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt};

   always @(negedge clk) begin
      logic [7:0] e;
      cycle_no++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if (out_vec !== e) begin
            n_fail++;
            $display("[TB] FAIL outputs cycle %0d: got %h expected %h", cycle_no, out_vec, e);
         end
      end
      n_tests++;
      if ((rd && wr) || (inc_pc && load_pc) || (wr && !datactl_ena)) begin
         n_fail++;
         $display("[TB] FAIL invariant cycle %0d: got %h expected no rd&wr, inc&load_pc, wr&!datactl",
                  cycle_no, out_vec);
      end
      if (load_ir)  cnt_ir++;
      if (inc_pc)   cnt_inc++;
      if (load_pc)  cnt_ld_pc++;
      if (load_acc) cnt_acc++;
      if (wr)       cnt_wr++;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cycle(input logic [7:0] v);
      exp_q.push_back(v);
      tick();
   endtask

   task automatic check_output(input string name, input int actual, input int expected);
      n_tests++;
      if (actual != expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] oprd_vec(input logic [2:0] op);
      case (op)
         OP_ADD, OP_AND, OP_XOR, OP_LDA: return 8'h08;
         OP_STO:                         return 8'h02;
         default:                        return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] exec_vec(input logic [2:0] op, input logic z);
      case (op)
         OP_ADD, OP_AND, OP_XOR, OP_LDA: return 8'h18;
         OP_STO:                         return 8'h06;
         OP_JMP:                         return 8'h20;
         OP_SKZ:                         return z ? 8'h40 : 8'h00;
         default:                        return 8'h00;
      endcase
   endfunction

   // One full five-cycle instruction starting in FETCH.
   task automatic apply_stimulus(input logic [2:0] op, input logic z);
      opcode = op;
      zero   = z;
      push_cycle(8'h88);
      push_cycle(8'h40);
      push_cycle(8'h00);
      push_cycle(oprd_vec(op));
      push_cycle(exec_vec(op, z));
   endtask

   initial begin
      int b_ir, b_inc, b_pc, b_acc, b_wr;
      logic [4:0] pc;

      rst_n  = 1'b0;
      opcode = OP_HLT;
      zero   = 1'b0;
      tick();
      push_cycle(8'h00);
      push_cycle(8'h00);
      check_output("reset_outputs", int'(out_vec), 0);
      rst_n = 1'b1;
      push_cycle(8'h00);

      b_ir = cnt_ir; b_inc = cnt_inc; b_acc = cnt_acc; b_wr = cnt_wr;
      for (int i = 0; i < 10; i++) apply_stimulus(OP_LDA, i[0]);
      check_output("lda_load_ir_count", cnt_ir - b_ir, 10);
      check_output("lda_inc_pc_count", cnt_inc - b_inc, 10);
      check_output("lda_load_acc_count", cnt_acc - b_acc, 10);
      check_output("lda_wr_count", cnt_wr - b_wr, 0);

      b_wr = cnt_wr;
      apply_stimulus(OP_STO, 1'b0);
      check_output("sto_wr_count", cnt_wr - b_wr, 1);

      b_inc = cnt_inc;
      apply_stimulus(OP_SKZ, 1'b1);
      pc = 5'h1E + 5'(cnt_inc - b_inc);
      check_output("skz_taken_inc_count", cnt_inc - b_inc, 2);
      check_output("skz_taken_pc_wrap", int'(pc), 0);

      b_inc = cnt_inc;
      apply_stimulus(OP_SKZ, 1'b0);
      pc = 5'h1E + 5'(cnt_inc - b_inc);
      check_output("skz_not_taken_inc_count", cnt_inc - b_inc, 1);
      check_output("skz_not_taken_pc", int'(pc), 31);

      b_pc = cnt_ld_pc;
      apply_stimulus(OP_JMP, 1'b1);
      check_output("jmp_load_pc_count", cnt_ld_pc - b_pc, 1);

      apply_stimulus(OP_ADD, 1'b1);
      apply_stimulus(OP_AND, 1'b0);
      apply_stimulus(OP_XOR, 1'b1);

      opcode = OP_HLT;
      zero   = 1'b0;
      push_cycle(8'h88);
      push_cycle(8'h40);
      push_cycle(8'h00);
      for (int i = 0; i < 20; i++) begin
         opcode = 3'($urandom_range(7, 0));
         zero   = 1'($urandom_range(1, 0));
         push_cycle(8'h01);
      end
      check_output("halt_sticky", int'(halt), 1);

      rst_n = 1'b0;
      #1;
      check_output("halt_async_clear", int'(halt), 0);
      check_output("async_reset_outputs", int'(out_vec), 0);
      push_cycle(8'h00);
      push_cycle(8'h00);
      rst_n = 1'b1;
      push_cycle(8'h00);
      apply_stimulus(OP_LDA, 1'b0);

      tick();
      tick();
      check_output("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
